// File: rtl/lsu_pkg.sv
// Shared types and lane-mask helper for the load/store unit.
// Optional feature macro used by this slice: LSU_MISALIGNED_EN.
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic [3:0] MASK_BYTE = 4'h1;
    localparam logic [3:0] MASK_HALF = 4'h3;
    localparam logic [3:0] MASK_WORD = 4'hF;

    // Byte-lane mask over two consecutive words; bits [7:4] belong to the next word.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] base;
        case (size)
            BYTE:    base = MASK_BYTE;
            HALF:    base = MASK_HALF;
            WORD:    base = MASK_WORD;
            default: base = 4'h0;
        endcase
        return {4'h0, base} << off;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: byte enables, store shift, load extract/extend.
// High-word datapath exists only when LSU_MISALIGNED_EN is defined.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_lo,
`ifdef LSU_MISALIGNED_EN
    input  logic [31:0] rdata_hi,
    output logic [3:0]  lane_hi,
    output logic [31:0] store_hi,
`endif
    output logic [3:0]  lane_lo,
    output logic [31:0] store_lo,
    output logic [31:0] load_data
);

    logic [7:0]  mask;
    logic [4:0]  shamt;
    logic [31:0] load_word;

    assign mask    = lane_mask(size, offset);
    assign shamt   = {offset, 3'b000};
    assign lane_lo = mask[3:0];

`ifdef LSU_MISALIGNED_EN
    assign lane_hi   = mask[7:4];
    assign store_lo  = 32'({32'h0, wdata} << shamt);
    assign store_hi  = 32'(({32'h0, wdata} << shamt) >> 32);
    assign load_word = 32'({rdata_hi, rdata_lo} >> shamt);
`else
    assign store_lo  = wdata << shamt;
    assign load_word = rdata_lo >> shamt;
`endif

    always_comb begin
        load_data = '0;
        case (size)
            BYTE: load_data = is_unsigned ? {24'h0, load_word[7:0]}
                                          : {{24{load_word[7]}}, load_word[7:0]};
            HALF: load_data = is_unsigned ? {16'h0, load_word[15:0]}
                                          : {{16{load_word[15]}}, load_word[15:0]};
            WORD: load_data = load_word;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit in front of dmem: request capture, access FSM, response.
// LSU_MISALIGNED_EN enables split (two-word) accesses; otherwise they fault.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DWIDTH-1:0] resp_rdata,
    output logic              resp_fault,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [3:0]        mem_wbe,
    output logic [DWIDTH-1:0] mem_dataw,
    input  logic [DWIDTH-1:0] mem_datar
);

    lsu_state_e state_q, state_d;

    logic              we_q, uns_q, fault_q;
    logic [1:0]        size_q;
    logic [AWIDTH+1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q, lo_q;
    logic              req_fault;
    logic [3:0]        lane_lo;
    logic [DWIDTH-1:0] store_lo, load_data;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:AWIDTH+2];

`ifdef LSU_MISALIGNED_EN
    logic [DWIDTH-1:0] hi_q;
    logic [3:0]        lane_hi;
    logic [DWIDTH-1:0] store_hi;

    assign req_fault = (req_size == 2'd3);
`else
    logic [7:0] req_mask;

    // Without the split path, any request touching the next word is refused up front.
    assign req_mask  = lane_mask(req_size, req_addr[1:0]);
    assign req_fault = (req_size == 2'd3) || (req_mask[7:4] != 4'h0);
`endif

    lsu_align u_align (
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata_lo    (lo_q),
`ifdef LSU_MISALIGNED_EN
        .rdata_hi    (hi_q),
        .lane_hi     (lane_hi),
        .store_hi    (store_hi),
`endif
        .lane_lo     (lane_lo),
        .store_lo    (store_lo),
        .load_data   (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            fault_q <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
`ifdef LSU_MISALIGNED_EN
            hi_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                fault_q <= req_fault;
                size_q  <= req_size;
                addr_q  <= req_addr[AWIDTH+1:0];
                wdata_q <= req_wdata;
            end
            if (state_q == ACC0) begin
                lo_q <= mem_datar;
            end
`ifdef LSU_MISALIGNED_EN
            if (state_q == ACC1) begin
                hi_q <= mem_datar;
            end
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_fault = 1'b0;
        resp_rdata = '0;
        mem_addr   = '0;
        mem_wbe    = '0;
        mem_dataw  = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = req_fault ? RESP : ACC0;
                end
            end
            ACC0: begin
                mem_addr  = addr_q[AWIDTH+1:2];
                mem_wbe   = we_q ? lane_lo : 4'h0;
                mem_dataw = store_lo;
`ifdef LSU_MISALIGNED_EN
                state_d   = (lane_hi != 4'h0) ? ACC1 : RESP;
`else
                state_d   = RESP;
`endif
            end
`ifdef LSU_MISALIGNED_EN
            ACC1: begin
                mem_addr  = addr_q[AWIDTH+1:2] + AWIDTH'(1);
                mem_wbe   = we_q ? lane_hi : 4'h0;
                mem_dataw = store_hi;
                state_d   = RESP;
            end
`endif
            RESP: begin
                resp_valid = 1'b1;
                resp_fault = fault_q;
                resp_rdata = (fault_q || we_q) ? '0 : load_data;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus random traffic against a byte-level model.
// Expectations follow LSU_MISALIGNED_EN when it is defined for the build.
module tb_lsu;

`ifdef LSU_MISALIGNED_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic [13:0] mem_addr;
    logic [3:0]  mem_wbe;
    logic [31:0] mem_dataw, mem_datar;

    lsu #(.DWIDTH(32), .AWIDTH(14)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_addr(mem_addr), .mem_wbe(mem_wbe), .mem_dataw(mem_dataw),
        .mem_datar(mem_datar)
    );

    always #5 clk = ~clk;

    // dmem: byte-enable synchronous write, asynchronous read
    logic [31:0] mem [16384];
    assign mem_datar = mem[mem_addr];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_wbe[b]) mem[mem_addr][8*b +: 8] <= mem_dataw[8*b +: 8];
    end

    // Reference memory, one entry per byte address
    bit [7:0] ref_mem [65536];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    // Observations of the last transaction
    logic [31:0] obs_addr [3];
    logic [3:0]  obs_wbe  [3];
    logic [31:0] obs_dataw[3];
    int          lat;
    logic        obs_fault;
    logic [31:0] obs_rdata;
    bit          wbe_seen;

    task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int guard = 0;
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) check("ready_wait", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; wbe_seen = 1'b0; obs_fault = 1'b0; obs_rdata = '0;
        for (int k = 0; k < 3; k++) begin
            obs_addr[k] = '0; obs_wbe[k] = '0; obs_dataw[k] = '0;
        end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c <= 3) begin
                obs_addr[c-1]  = 32'(mem_addr);
                obs_wbe[c-1]   = mem_wbe;
                obs_dataw[c-1] = mem_dataw;
            end
            if (mem_wbe != 4'h0) wbe_seen = 1'b1;
            if (resp_valid) begin
                lat = c; obs_fault = resp_fault; obs_rdata = resp_rdata;
                break;
            end
        end
    endtask

    // Expected behaviour computed from the byte-level access rules
    task automatic model_check(input bit we, input logic [1:0] size, input bit uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
        int          n     = 1 << size;
        int          off   = int'(addr[1:0]);
        int          base  = int'(addr[15:0]);
        bit          split = (off + n) > 4;
        bit          fault = (size == 2'd3) || (split && !EN);
        int          exp_lat = fault ? 1 : (split ? 3 : 2);
        logic [31:0] val = '0;
        check("latency", 32'(lat), 32'(exp_lat));
        check("fault", {31'b0, obs_fault}, {31'b0, fault});
        if (!we && !fault) begin
            for (int i = 0; i < n; i++) val |= 32'(ref_mem[(base + i) & 16'hFFFF]) << (8 * i);
            if (!uns && n == 1 && val[7])  val |= 32'hFFFF_FF00;
            if (!uns && n == 2 && val[15]) val |= 32'hFFFF_0000;
        end
        check("rdata", obs_rdata, val);
        if (!we || fault) begin
            check("no_write", {31'b0, wbe_seen}, 32'd0);
        end else begin
            for (int i = 0; i < n; i++) ref_mem[(base + i) & 16'hFFFF] = wdata[8*i +: 8];
        end
        for (int i = 0; i < 4; i++) begin
            int w = ((base + i) & 16'hFFFF) >> 2;
            check("mem_word", mem[w], ref_word(w));
        end
    endtask

    task automatic txn(input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
        do_req(we, size, uns, addr, wdata);
        model_check(we, size, uns, addr, wdata);
    endtask

    initial begin
        bit saw_resp;
        logic [31:0] hi16, a16, wd;
        int r;
        logic [1:0] sz;

        for (int w = 0; w < 16384; w++) mem[w] = '0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        #3;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        check("rst_wbe", {28'b0, mem_wbe}, 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_dataw", mem_dataw, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_fault", {31'b0, resp_fault}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        txn(1'b1, 2'd2, 1'b0, 32'h0, 32'hdeadbeef);
        check("sw0_wbe", {28'b0, obs_wbe[0]}, 32'hF);
        check("sw0_addr", obs_addr[0], 32'd0);
        check("sw0_mem", mem[0], 32'hdeadbeef);

        txn(1'b1, 2'd0, 1'b0, 32'h5, 32'hcafebabe);
        check("sb5_wbe", {28'b0, obs_wbe[0]}, 32'h2);
        check("sb5_dataw", obs_dataw[0], 32'hfebabe00);
        check("sb5_mem", mem[1], 32'h0000be00);
        txn(1'b0, 2'd0, 1'b0, 32'h5, 32'h0);
        check("lb5", obs_rdata, 32'hffffffbe);
        txn(1'b0, 2'd0, 1'b1, 32'h5, 32'h0);
        check("lbu5", obs_rdata, 32'h000000be);

        txn(1'b1, 2'd2, 1'b0, 32'h6, 32'h11223344);
        if (EN) begin
            check("sw6_a0", obs_addr[0], 32'd1);
            check("sw6_w0", {28'b0, obs_wbe[0]}, 32'hC);
            check("sw6_d0", obs_dataw[0], 32'h33440000);
            check("sw6_a1", obs_addr[1], 32'd2);
            check("sw6_w1", {28'b0, obs_wbe[1]}, 32'h3);
            check("sw6_d1", obs_dataw[1], 32'h00001122);
        end
        txn(1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
        if (EN) check("lw6", obs_rdata, 32'h11223344);

        txn(1'b0, 2'd1, 1'b0, 32'h0000FFFF, 32'h0);
        if (EN) begin
            check("lh_top_a0", obs_addr[0], 32'd16383);
            check("lh_top_a1", obs_addr[1], 32'd0);
        end
        txn(1'b1, 2'd3, 1'b0, 32'h10, 32'h12345678);

        // Reset during the access: ACC1 of a split store, or ACC0 of an aligned one
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = EN ? 32'h6 : 32'h8; req_wdata = 32'haabbccdd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        if (EN) begin
            ref_mem[6] = 8'hdd;
            ref_mem[7] = 8'hcc;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        check("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
        check("mid_rst_wbe", {28'b0, mem_wbe}, 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_dataw", mem_dataw, 32'd0);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        saw_resp = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        check("mid_rst_no_resp", {31'b0, saw_resp}, 32'd0);
        check("mid_rst_mem1", mem[1], ref_word(1));
        check("mid_rst_mem2", mem[2], ref_word(2));

        // Random traffic at low addresses and around the top-of-memory wrap
        for (int t = 0; t < 300; t++) begin
            hi16 = $urandom();
            if ($urandom_range(0, 3) == 0) a16 = 32'hFFFF - $urandom_range(0, 7);
            else                           a16 = $urandom_range(0, 63);
            r  = $urandom_range(0, 15);
            sz = (r == 0) ? 2'd3 : 2'(r % 3);
            wd = $urandom();
            txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                {hi16[15:0], a16[15:0]}, wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
